// File: rtl/ring_osc_pkg.sv
// ring_osc_pkg: FSM state type, default parameters and saturating increment shared by the ring oscillator meter
package ring_osc_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;
  localparam int DEF_NUM_RINGS   = 4;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_GATE_W      = 16;
  localparam int DEF_SETTLE_CYC  = 8;
  localparam int DEF_SYNC_STAGES = 2;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v == max) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/ring_osc_sync.sv
// ring_osc_sync: synchroniser chain for one asynchronous ring signal with a rising-edge pulse (d_i async in, rise_o one-cycle pulse)
module ring_osc_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  always_ff @(posedge clk)
    sync_q <= !rst_n ? '0 : {sync_q[SYNC_STAGES-2:0], d_i};
  // newest of the last two stages high while the older one is still low
  assign rise_o = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/ring_osc_meter.sv
// ring_osc_meter: enables one ring, counts its synchronised rising edges over gate_len clk cycles (clk/rst_n/ena, ring_in->ring_en, sel/gate_len/start -> busy/done/count/overflow; RING_OSC_METER_CONT_EN adds cont)
module ring_osc_meter
  import ring_osc_pkg::*;
#(
  parameter int NUM_RINGS   = DEF_NUM_RINGS,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int GATE_W      = DEF_GATE_W,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic [NUM_RINGS-1:0]         ring_in,
  output logic [NUM_RINGS-1:0]         ring_en,
  input  logic [$clog2(NUM_RINGS)-1:0] sel,
  input  logic [GATE_W-1:0]            gate_len,
  input  logic                         start,
`ifdef RING_OSC_METER_CONT_EN
  input  logic                         cont,
`endif
  output logic                         busy,
  output logic                         done,
  output logic [CNT_W-1:0]             count,
  output logic                         overflow
);
  localparam int SW = $clog2(NUM_RINGS);
  localparam int TW = (GATE_W > $clog2(SETTLE_CYC + 1)) ? GATE_W : $clog2(SETTLE_CYC + 1);
  state_t st_q, st_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, count_q, count_d;
  logic ovf_q, ovf_d, overflow_q, overflow_d;
  logic in_range, ring_mux, rise, cont_w;
`ifdef RING_OSC_METER_CONT_EN
  assign cont_w = cont;
`else
  assign cont_w = 1'b0;
`endif
  // an out-of-range select behaves like a silent ring
  assign in_range = 32'(sel_q) < NUM_RINGS;
  assign ring_mux = in_range ? ring_in[sel_q] : 1'b0;
  ring_osc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ring_mux),
    .rise_o(rise)
  );
  always_comb begin
    st_d       = st_q;
    sel_d      = sel_q;
    gate_d     = gate_q;
    tmr_d      = tmr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (!ena) st_d = IDLE;
    else begin
      case (st_q)
        IDLE: if (start) begin
          st_d   = SETTLE;
          sel_d  = sel;
          gate_d = gate_len;
          tmr_d  = TW'(SETTLE_CYC - 1);
        end
        SETTLE: begin
          cnt_d = '0;
          ovf_d = 1'b0;
          st_d  = (tmr_q != '0) ? SETTLE : (gate_q == '0) ? DONE : MEASURE;
          tmr_d = (tmr_q != '0) ? tmr_q - TW'(1) : TW'(gate_q) - TW'(1);
        end
        MEASURE: begin
          cnt_d = rise ? CNT_W'(sat_inc(32'(cnt_q), 32'({CNT_W{1'b1}}))) : cnt_q;
          ovf_d = ovf_q | (rise & (cnt_q == '1));
          st_d  = (tmr_q == '0) ? DONE : MEASURE;
          tmr_d = tmr_q - TW'(1);
        end
        default: begin
          st_d  = cont_w ? SETTLE : IDLE;
          tmr_d = TW'(SETTLE_CYC - 1);
        end
      endcase
      // result is captured on entry to DONE so it is valid while done is high
      if (st_q != DONE && st_d == DONE) begin
        count_d    = cnt_d;
        overflow_d = ovf_d;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q       <= IDLE;
      sel_q      <= '0;
      gate_q     <= '0;
      tmr_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      sel_q      <= sel_d;
      gate_q     <= gate_d;
      tmr_q      <= tmr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end
  assign busy     = (st_q == SETTLE) || (st_q == MEASURE);
  assign done     = st_q == DONE;
  assign ring_en  = (st_q != IDLE && in_range) ? NUM_RINGS'(1) << sel_q : '0;
  assign count    = count_q;
  assign overflow = overflow_q;
endmodule
